// File: rtl/itr_controller.sv
// Interrupt controller: edge-detects NSRC request lines, keeps masked pending bits,
// and raises a one-cycle itr for the lowest pending index, then waits for a software ack.
module itr_controller #(
    parameter int NUBITS = 16,
    parameter int NSRC   = 4,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int STADR  = 0,
    parameter int ACKADR = 0,
    parameter int MSKADR = 1,
    parameter int MINGAP = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NSRC-1:0]                           src_req,
    input  logic                                      cpu_req_in,
    input  logic [((NUIOIN > 1) ? $clog2(NUIOIN) : 1)-1:0] cpu_addr_in,
    output logic [NUBITS-1:0]                         cpu_data,
    input  logic                                      cpu_out_en,
    input  logic [((NUIOOU > 1) ? $clog2(NUIOOU) : 1)-1:0] cpu_addr_out,
    input  logic [NUBITS-1:0]                         cpu_io_out,
    output logic                                      itr,
    output logic                                      in_service
);

    localparam int ID_W  = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int AI_W  = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int AO_W  = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
    localparam int GAP_W = (MINGAP > 1) ? $clog2(MINGAP) : 1;

    localparam logic [AI_W-1:0]  ST_A     = AI_W'(STADR);
    localparam logic [AO_W-1:0]  ACK_A    = AO_W'(ACKADR);
    localparam logic [AO_W-1:0]  MSK_A    = AO_W'(MSKADR);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MINGAP - 1);

    typedef enum logic [1:0] {IDLE, FIRE, WAIT, GAP} state_t;

    state_t            state, state_nxt;
    logic [NSRC-1:0]   src_q, pending, mask;
    logic [NSRC-1:0]   evt, elig, clr;
    logic [ID_W-1:0]   cur_id, pick_id;
    logic [GAP_W-1:0]  gap_cnt;
    logic              wr_ack, wr_msk, ack_vld;
    logic              unused_io;

    assign unused_io = ^cpu_io_out;

    assign evt     = src_req & ~src_q;
    assign elig    = pending & mask;
    assign wr_ack  = cpu_out_en && (cpu_addr_out == ACK_A);
    assign wr_msk  = cpu_out_en && (cpu_addr_out == MSK_A);
    assign ack_vld = wr_ack && (state == WAIT);
    assign clr     = ack_vld ? (NSRC'(1) << cur_id) : '0;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        pick_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) pick_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        itr        = 1'b0;
        in_service = 1'b0;
        case (state)
            IDLE: if (|elig) state_nxt = FIRE;
            FIRE: begin
                itr        = 1'b1;
                in_service = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                in_service = 1'b1;
                if (ack_vld) state_nxt = GAP;
            end
            GAP:  if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Set beats clear on a same-cycle collision because evt is OR'd in last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q   <= '0;
            pending <= '0;
            mask    <= '1;
            cur_id  <= '0;
            gap_cnt <= '0;
        end else begin
            src_q   <= src_req;
            pending <= (pending & ~clr) | evt;
            if (wr_msk) mask <= cpu_io_out[NSRC-1:0];
            if (state == IDLE && (|elig)) cur_id <= pick_id;
            if (ack_vld)
                gap_cnt <= GAP_LOAD;
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    always_comb begin
        cpu_data = '0;
        if (cpu_req_in && (cpu_addr_in == ST_A)) begin
            cpu_data[NUBITS-1] = in_service;
            if (NSRC > 1) cpu_data[ID_W-1:0] = cur_id;
        end
    end

endmodule

// File: tb/tb_itr_controller.sv
// Self-checking bench for itr_controller: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a flag/counter service model.
module tb_itr_controller;

    localparam int MINGAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  src_req = '0;
    logic        cpu_req_in = 1'b0;
    logic [0:0]  cpu_addr_in = '0;
    logic [15:0] cpu_data;
    logic        cpu_out_en = 1'b0;
    logic [0:0]  cpu_addr_out = '0;
    logic [15:0] cpu_io_out = '0;
    logic        itr;
    logic        in_service;

    int n_checks = 0;
    int n_fail   = 0;

    itr_controller #(.NUBITS(16), .NSRC(4), .NUIOIN(2), .NUIOOU(2),
                     .STADR(0), .ACKADR(0), .MSKADR(1), .MINGAP(MINGAP)) dut (
        .clk(clk), .rst(rst), .src_req(src_req),
        .cpu_req_in(cpu_req_in), .cpu_addr_in(cpu_addr_in), .cpu_data(cpu_data),
        .cpu_out_en(cpu_out_en), .cpu_addr_out(cpu_addr_out), .cpu_io_out(cpu_io_out),
        .itr(itr), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Service model: m_svc = source in service, m_fire = pulse cycle,
    // m_cool = remaining cycles of the post-ack quiet period.
    logic [3:0] m_pend, m_mask, m_prev;
    logic       m_svc, m_fire;
    int         m_cool, m_cur;
    logic [3:0] n_pend, n_mask;
    logic       n_svc, n_fire;
    int         n_cool, n_cur;
    logic       t_ack, t_msk;

    always_comb begin
        n_pend = m_pend;
        n_mask = m_mask;
        n_svc  = m_svc;
        n_fire = 1'b0;
        n_cool = m_cool;
        n_cur  = m_cur;
        t_ack  = cpu_out_en && (cpu_addr_out == 1'b0);
        t_msk  = cpu_out_en && (cpu_addr_out == 1'b1);
        if (m_fire) begin
            n_fire = 1'b0;
        end else if (m_svc) begin
            if (t_ack) begin
                n_pend[m_cur] = 1'b0;
                n_svc  = 1'b0;
                n_cool = MINGAP;
            end
        end else if (m_cool > 0) begin
            n_cool = m_cool - 1;
        end else if ((m_pend & m_mask) != 4'd0) begin
            for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) n_cur = i;
            n_fire = 1'b1;
            n_svc  = 1'b1;
        end
        n_pend = n_pend | (src_req & ~m_prev);
        if (t_msk) n_mask = cpu_io_out[3:0];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= '0; m_mask <= 4'hF; m_prev <= '0;
            m_svc <= 1'b0; m_fire <= 1'b0; m_cool <= 0; m_cur <= 0;
        end else begin
            m_pend <= n_pend; m_mask <= n_mask; m_prev <= src_req;
            m_svc <= n_svc; m_fire <= n_fire; m_cool <= n_cool; m_cur <= n_cur;
        end
    end

    always @(negedge clk) begin
        int exp_data;
        exp_data = 0;
        if (cpu_req_in && cpu_addr_in == 1'b0) exp_data = (m_svc ? 32'h8000 : 0) | m_cur;
        chk("model_itr", int'(itr), int'(m_fire));
        chk("model_in_service", int'(in_service), int'(m_svc));
        chk("model_cpu_data", int'(cpu_data), exp_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic a, input logic [15:0] d);
        cpu_out_en = 1'b1; cpu_addr_out = a; cpu_io_out = d;
        tick();
        cpu_out_en = 1'b0;
    endtask

    task automatic wait_itr(input int lim, output int n);
        n = -1;
        for (int k = 1; k <= lim; k++) begin
            tick();
            if (itr) begin n = k; break; end
        end
    endtask

    task automatic read_status(output int v);
        cpu_req_in = 1'b1; cpu_addr_in = 1'b0;
        #1;
        v = int'(cpu_data);
        cpu_req_in = 1'b0;
    endtask

    initial begin
        int n, v;
        #1 rst = 1'b1;
        tick(); tick();
        cpu_req_in = 1'b1; cpu_addr_in = 1'b0;
        #1;
        chk("reset_itr", int'(itr), 0);
        chk("reset_in_service", int'(in_service), 0);
        chk("reset_status", int'(cpu_data), 0);
        cpu_req_in = 1'b0;
        @(negedge clk); #1 rst = 1'b0;
        tick(); tick(); tick();

        // Single event on source 2, latency, status, ack and quiet period
        src_req[2] = 1'b1;
        tick(); chk("lat_n1_itr", int'(itr), 0);
        tick(); chk("lat_n2_itr", int'(itr), 1);
        read_status(v); chk("status_src2", v, 32'h8002);
        tick(); chk("pulse_one_cycle", int'(itr), 0);
        chk("in_service_wait", int'(in_service), 1);
        tick();
        io_write(1'b0, 16'(($urandom)));
        chk("in_service_after_ack", int'(in_service), 0);
        src_req[2] = 1'b0; src_req[0] = 1'b1;
        wait_itr(12, n); chk("gap_itr_delay", n, 5);
        read_status(v); chk("status_src0", v, 32'h8000);
        tick(); io_write(1'b0, 16'h0); src_req[0] = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Simultaneous edges on 3 and 1
        src_req[3] = 1'b1; src_req[1] = 1'b1;
        wait_itr(6, n); chk("prio_first_delay", n, 2);
        read_status(v); chk("prio_first_id", v, 32'h8001);
        tick(); io_write(1'b0, 16'h0);
        wait_itr(12, n); chk("prio_second_delay", n, 5);
        read_status(v); chk("prio_second_id", v, 32'h8003);
        tick(); io_write(1'b0, 16'h0); src_req = '0;
        wait_itr(10, n); chk("no_itr_after_queue", n, -1);

        // Masking source 0
        io_write(1'b1, 16'hE);
        src_req[0] = 1'b1;
        wait_itr(6, n); chk("masked_no_itr", n, -1);
        src_req[0] = 1'b0;
        io_write(1'b1, 16'hF);
        wait_itr(6, n); chk("unmask_delay", n, 1);
        read_status(v); chk("unmask_id", v, 32'h8000);
        tick(); io_write(1'b0, 16'h0);
        for (int i = 0; i < 8; i++) tick();

        // Spurious ack in IDLE
        io_write(1'b0, 16'hFFFF);
        tick();
        src_req[0] = 1'b1;
        wait_itr(6, n); chk("after_spurious_delay", n, 2);
        tick(); io_write(1'b0, 16'h0); src_req[0] = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // New edge on source 1 in the same cycle as its ack
        src_req[1] = 1'b1;
        wait_itr(6, n); chk("collide_first_delay", n, 2);
        src_req[1] = 1'b0;
        tick(); tick();
        cpu_out_en = 1'b1; cpu_addr_out = 1'b0; src_req[1] = 1'b1;
        tick();
        cpu_out_en = 1'b0;
        wait_itr(12, n); chk("collide_second_delay", n, 5);
        read_status(v); chk("collide_second_id", v, 32'h8001);
        tick(); io_write(1'b0, 16'h0); src_req[1] = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Asynchronous reset while waiting for ack
        src_req[3] = 1'b1;
        wait_itr(6, n); chk("pre_reset_delay", n, 2);
        tick();
        #1 rst = 1'b1;
        #1 cpu_req_in = 1'b1; cpu_addr_in = 1'b0;
        #1;
        chk("async_rst_itr", int'(itr), 0);
        chk("async_rst_in_service", int'(in_service), 0);
        chk("async_rst_status", int'(cpu_data), 0);
        cpu_req_in = 1'b0;
        @(negedge clk); #1 rst = 1'b0;
        tick(); chk("post_reset_edge1_itr", int'(itr), 0);
        tick(); chk("post_reset_edge2_itr", int'(itr), 1);
        tick(); io_write(1'b0, 16'h0); src_req = '0;
        for (int i = 0; i < 8; i++) tick();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] flip;
            tick();
            if ($urandom_range(0, 499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 5) == 0);
            src_req      = src_req ^ flip;
            cpu_out_en   = ($urandom_range(0, 3) == 0);
            cpu_addr_out = 1'($urandom_range(0, 1));
            cpu_io_out   = 16'($urandom);
            cpu_req_in   = 1'($urandom_range(0, 1));
            cpu_addr_in  = 1'($urandom_range(0, 1));
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", n_fail);
        $fatal(1);
    end

endmodule
